// File: rtl/ahb_sram_slave.sv
// ---------------------------------------------------------------------------
// ahb_sram_slave
//
// Single-port SRAM behind an AHB-Lite slave interface. Word (32-bit) accesses
// only, back-to-back pipelined transfers, and a fixed number of wait states
// inserted into every data phase.
//
// Optional feature (compile-time macro AHB_SRAM_SLAVE_ERR_EN):
//   defined   - out-of-range or misaligned addresses get a two-cycle ERROR
//               response (ERR1 -> ERR2) with no memory access.
//   undefined - no error checking; addresses alias modulo DEPTH and
//               haddr[1:0] is ignored; o_hresp is constant 0.
//
// Ports:
//   i_clk_ahb  in   1           bus clock, rising edge
//   i_rst_ahb  in   1           synchronous active-high reset
//   i_hsel     in   1           slave select
//   i_haddr    in   ADDR_WIDTH  byte address (address phase)
//   i_htrans   in   2           IDLE/BUSY/NONSEQ/SEQ
//   i_hwrite   in   1           1 = write, 0 = read
//   i_hwdata   in   DATA_WIDTH  write data (data phase)
//   o_hrdata   out  DATA_WIDTH  read data (data phase), 0 when not reading
//   o_hready   out  1           data phase completes this cycle
//   o_hresp    out  1           0 OKAY, 1 ERROR
// ---------------------------------------------------------------------------
module ahb_sram_slave #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DEPTH       = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    WAIT_STATES = 0
) (
    input  logic                  i_clk_ahb,
    input  logic                  i_rst_ahb,
    input  logic                  i_hsel,
    input  logic [ADDR_WIDTH-1:0] i_haddr,
    input  logic [1:0]            i_htrans,
    input  logic                  i_hwrite,
    input  logic [DATA_WIDTH-1:0] i_hwdata,
    output logic [DATA_WIDTH-1:0] o_hrdata,
    output logic                  o_hready,
    output logic                  o_hresp
);

    localparam int                    IDX_W   = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] SPAN    = ADDR_WIDTH'(DEPTH * 4);
    // Last wait-counter value before the data phase; unused when WAIT_STATES=0.
    localparam logic [3:0]            WS_LAST = 4'(WAIT_STATES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DATA,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            wait_cnt_q, wait_cnt_d;
    logic [IDX_W-1:0]      idx_q;
    logic                  write_q;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  capture;
    logic                  addr_err;
    logic [ADDR_WIDTH-1:0] offset;
    logic [IDX_W-1:0]      addr_idx;

    // Address decode. Subtracting the base makes any address below BASE_ADDR
    // wrap to a large offset, so a single compare covers both range ends.
    assign offset   = i_haddr - BASE_ADDR;
    assign addr_idx = offset[IDX_W+1:2];

`ifdef AHB_SRAM_SLAVE_ERR_EN
    assign addr_err = (offset >= SPAN) || (offset[1:0] != 2'b00);
`else
    assign addr_err = 1'b0;
`endif

    // Only upper offset bits and htrans[0] may go unread, depending on build.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{offset, i_htrans[0], SPAN};

    // A transfer is taken only when the previous data phase is finishing.
    assign capture = o_hready && i_hsel && i_htrans[1];

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = '0;
        o_hready   = 1'b1;
        o_hresp    = 1'b0;
        o_hrdata   = '0;

        case (state_q)
            S_WAIT: begin
                o_hready = 1'b0;
                if (wait_cnt_q == WS_LAST) begin
                    state_d = S_DATA;
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            S_ERR1: begin
                o_hready = 1'b0;
                o_hresp  = 1'b1;
                state_d  = S_ERR2;
            end
            default: begin
                // IDLE, DATA and ERR2 all close with hready high and share
                // the same next-transfer decision.
                if (state_q == S_ERR2) begin
                    o_hresp = 1'b1;
                end
                if (state_q == S_DATA && !write_q) begin
                    o_hrdata = mem[idx_q];
                end
                if (!capture) begin
                    state_d = S_IDLE;
                end else if (addr_err) begin
                    state_d = S_ERR1;
                end else if (WAIT_STATES > 0) begin
                    state_d = S_WAIT;
                end else begin
                    state_d = S_DATA;
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge i_clk_ahb) begin
        if (i_rst_ahb) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= '0;
            idx_q      <= '0;
            write_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            if (capture) begin
                idx_q   <= addr_idx;
                write_q <= i_hwrite;
            end
        end
    end

    // NOTE: the array has no reset so it maps onto plain SRAM; reset only
    // blocks a write that would otherwise commit on the reset edge.
    always_ff @(posedge i_clk_ahb) begin
        if (!i_rst_ahb && state_q == S_DATA && write_q) begin
            mem[idx_q] <= i_hwdata;
        end
    end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// ---------------------------------------------------------------------------
// tb_ahb_sram_slave
//
// Three slaves with WAIT_STATES = 0, 2 and 3, each driven by its own master
// thread. The master pushes the expected transfer into a per-slave queue when
// the address phase is accepted; a monitor pops at the hready-high cycle that
// ends the data phase and compares against a word-array reference memory.
// ---------------------------------------------------------------------------
module tb_ahb_sram_slave;

    localparam int          NI    = 3;
    localparam int          DEPTH = 256;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10;

    typedef struct {
        bit          err;
        bit          wr;
        int          idx;
        logic [31:0] wdata;
    } exp_t;

    logic        clk;
    logic        rst    [NI];
    logic        hsel   [NI];
    logic [31:0] haddr  [NI];
    logic [1:0]  htrans [NI];
    logic        hwrite [NI];
    logic [31:0] hwdata [NI];
    logic [31:0] hrdata [NI];
    logic        hready [NI];
    logic        hresp  [NI];

    exp_t        sb    [NI][$];
    logic [31:0] mem_m [NI][DEPTH];
    int          lowc  [NI];
    int          n_vec = 0;
    int          n_bad = 0;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        ahb_sram_slave #(
            .DATA_WIDTH (32),
            .ADDR_WIDTH (32),
            .DEPTH      (DEPTH),
            .BASE_ADDR  (BASE),
            .WAIT_STATES(g == 0 ? 0 : g + 1)
        ) u_dut (
            .i_clk_ahb(clk),
            .i_rst_ahb(rst[g]),
            .i_hsel   (hsel[g]),
            .i_haddr  (haddr[g]),
            .i_htrans (htrans[g]),
            .i_hwrite (hwrite[g]),
            .i_hwdata (hwdata[g]),
            .o_hrdata (hrdata[g]),
            .o_hready (hready[g]),
            .o_hresp  (hresp[g])
        );
    end

    always #5 clk = ~clk;

    function automatic int ws_of(int k);
        return (k == 0) ? 0 : k + 1;
    endfunction

    // Reference decode: word offset from the base, wrapped into the array;
    // errors only exist when the checking feature is compiled in.
    function automatic exp_t mk(logic [31:0] a, bit wr, logic [31:0] wd);
        exp_t        e;
        logic [31:0] off;
        off     = a - BASE;
        e.wr    = wr;
        e.wdata = wd;
        e.idx   = int'((off / 4) % DEPTH);
`ifdef AHB_SRAM_SLAVE_ERR_EN
        e.err   = (off >= 32'(DEPTH * 4)) || (a % 4 != 0);
`else
        e.err   = 1'b0;
`endif
        return e;
    endfunction

    task automatic check(string nm, int k, logic [31:0] got, logic [31:0] req);
        n_vec++;
        if (got !== req) begin
            n_bad++;
            $display("FAIL %s[slave %0d] @%0t: got %h required %h", nm, k, $time, got, req);
        end
    endtask

    // Monitor: outside a data phase the slave must look idle; inside one it
    // counts hready-low cycles and compares the closing response.
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] rexp;
        for (int k = 0; k < NI; k++) begin
            if (rst[k]) begin
                lowc[k] = 0;
                continue;
            end
            if (sb[k].size() == 0) begin
                check("idle_hready", k, 32'(hready[k]), 32'd1);
                check("idle_hresp",  k, 32'(hresp[k]),  32'd0);
                check("idle_hrdata", k, hrdata[k],      32'd0);
            end else begin
                e = sb[k][0];
                if (!hready[k]) begin
                    lowc[k]++;
                    check("wait_hresp",  k, 32'(hresp[k]), 32'(e.err));
                    check("wait_hrdata", k, hrdata[k],     32'd0);
                end else begin
                    rexp = (e.err || e.wr) ? 32'd0 : mem_m[k][e.idx];
                    check("low_cycles", k, 32'(lowc[k]), 32'(e.err ? 1 : ws_of(k)));
                    check("resp",       k, 32'(hresp[k]), 32'(e.err));
                    check("rdata",      k, hrdata[k],     rexp);
                    if (!e.err && e.wr) mem_m[k][e.idx] = e.wdata;
                    void'(sb[k].pop_front());
                    lowc[k] = 0;
                end
            end
        end
    end

    // One address phase: hold it until the slave is ready, then move the
    // write data into the data phase that follows.
    task automatic issue(int k, bit sel, logic [1:0] tr, bit wr,
                         logic [31:0] a, logic [31:0] wd);
        bit rdy;
        int n = 0;
        hsel[k]   = sel;
        htrans[k] = tr;
        hwrite[k] = wr;
        haddr[k]  = a;
        do begin
            @(negedge clk);
            rdy = hready[k];
            @(posedge clk);
            n++;
        end while (!rdy && n < 64);
        if (!rdy) begin
            n_vec++;
            n_bad++;
            $display("FAIL accept[slave %0d]: hready got 0 required 1 within 64 cycles", k);
        end else if (sel && tr[1]) begin
            sb[k].push_back(mk(a, wr, wd));
        end
        #1;
        hwdata[k] = wd;
    endtask

    task automatic reset_mid_write(int k);
        issue(k, 1, T_NSEQ, 1, 32'h20, 32'h0BAD_F00D);
        rst[k] = 1'b1;
        sb[k].delete();
        hsel[k]   = 1'b0;
        htrans[k] = T_IDLE;
        repeat (2) @(posedge clk);
        #1;
        rst[k] = 1'b0;
        issue(k, 1, T_NSEQ, 0, 32'h20, 32'h0);
    endtask

    task automatic run(int k);
        logic [31:0] a;
        int          r;
        for (int i = 0; i < DEPTH; i++) issue(k, 1, T_NSEQ, 1, 32'(i * 4), $urandom);
        // Back-to-back write then read of the same word.
        issue(k, 1, T_NSEQ, 1, 32'h10, 32'hDEAD_BEEF);
        issue(k, 1, T_NSEQ, 0, 32'h10, 32'h0);
        issue(k, 1, T_NSEQ, 1, 32'h4,  32'h1234_5678);
        issue(k, 0, T_IDLE, 0, 32'h0,  32'h0);
        issue(k, 1, T_NSEQ, 0, 32'h4,  32'h0);
        // Non-transfers must not touch memory.
        issue(k, 1, T_IDLE, 1, 32'h8,  32'hFFFF_0000);
        issue(k, 1, T_BUSY, 1, 32'h8,  32'hFFFF_0001);
        issue(k, 0, T_NSEQ, 1, 32'h8,  32'hFFFF_0002);
        issue(k, 1, T_NSEQ, 0, 32'h8,  32'h0);
        // Out-of-range read, misaligned write, then the neighbouring word.
        issue(k, 1, T_NSEQ, 0, 32'h400, 32'h0);
        issue(k, 1, T_NSEQ, 1, 32'h6,   32'hBAD0_BAD0);
        issue(k, 1, T_NSEQ, 0, 32'h4,   32'h0);
        // Aliasing one array-span above the base.
        issue(k, 1, T_NSEQ, 1, 32'h404, 32'hA5A5_A5A5);
        issue(k, 1, T_NSEQ, 0, 32'h4,   32'h0);
        if (k == 2) reset_mid_write(k);
        for (int i = 0; i < 150; i++) begin
            r = int'($urandom % 10);
            if (r < 7)       a = 32'(($urandom % DEPTH) * 4);
            else if (r == 7) a = 32'(($urandom % DEPTH) * 4 + 1 + $urandom % 3);
            else if (r == 8) a = 32'(DEPTH * 4 + ($urandom % DEPTH) * 4);
            else             a = $urandom;
            issue(k, ($urandom % 8) != 0, 2'($urandom), 1'($urandom), a, $urandom);
        end
        issue(k, 0, T_IDLE, 0, 32'h0, 32'h0);
    endtask

    initial begin
        clk = 1'b0;
        for (int k = 0; k < NI; k++) begin
            rst[k]    = 1'b1;
            hsel[k]   = 1'b0;
            htrans[k] = T_IDLE;
            hwrite[k] = 1'b0;
            haddr[k]  = '0;
            hwdata[k] = '0;
            lowc[k]   = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) rst[k] = 1'b0;

        fork
            run(0);
            run(1);
            run(2);
        join

        for (int t = 0; t < 50 && (sb[0].size() + sb[1].size() + sb[2].size()) != 0; t++)
            @(negedge clk);
        if ((sb[0].size() + sb[1].size() + sb[2].size()) != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain: %0d transfers still outstanding, required 0",
                     sb[0].size() + sb[1].size() + sb[2].size());
        end
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
